// File: rtl/ara_mask_popc_acc_pkg.sv
// Shared types and helpers for the vcpop.m / vfirst.m mask-reduction stage.
`default_nettype none

package ara_mask_popc_acc_pkg;

  typedef enum logic {
    POPC_CNT   = 1'b0,
    POPC_FIRST = 1'b1
  } popc_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } popc_state_e;

  // Keeps the low n bits of a word; full overrides n when 64 or more bits remain.
  function automatic logic [63:0] tail_mask(input logic [5:0] n, input logic full);
    if (full) return '1;
    return (64'd1 << n) - 64'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ara_mask_popc_acc_bitops.sv
// Population count and trailing-zero count of one 64-bit mask word.
`default_nettype none

module ara_mask_popc_acc_bitops (
  input  logic [63:0] i_word,
  output logic [6:0]  o_popc,
  output logic [5:0]  o_tz
);

  always_comb begin
    o_popc = '0;
    for (int i = 0; i < 64; i++) begin
      o_popc = o_popc + 7'(i_word[i]);
    end
  end

  // Scanning downward leaves the lowest set index; zero words are gated by the caller.
  always_comb begin
    o_tz = '0;
    for (int i = 63; i >= 0; i--) begin
      if (i_word[i]) o_tz = 6'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/ara_mask_popc_acc.sv
// Sequential mask reduction: accumulates popcount (vcpop.m) or finds the first set bit (vfirst.m).
`default_nettype none

module ara_mask_popc_acc
  import ara_mask_popc_acc_pkg::*;
#(
  parameter int unsigned MaxVl = 16384,
  parameter int unsigned CntW  = $clog2(MaxVl + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  popc_op_e        op_i,
  input  logic [CntW-1:0] vl_i,
  output logic            busy_o,
  input  logic            mask_valid_i,
  output logic            mask_ready_o,
  input  logic [63:0]     mask_i,
  input  logic [63:0]     en_i,
  output logic            result_valid_o,
  input  logic            result_ready_i,
  output logic [63:0]     result_o
);

  localparam int unsigned BeatW = CntW - 6;

  popc_state_e      r_state, w_state_next;
  popc_op_e         r_op;
  logic [CntW-1:0]  r_bits_left;
  logic [BeatW-1:0] r_beat;
  logic [CntW-1:0]  r_acc;
  logic [CntW-1:0]  r_first;
  logic             r_found;

  logic             w_start;
  logic             w_hs;
  logic             w_full;
  logic [CntW-1:0]  w_take;
  logic [63:0]      w_word;
  logic [6:0]       w_popc;
  logic [5:0]       w_tz;

  assign w_start = start_i && (r_state == ST_IDLE);
  assign w_hs    = mask_valid_i && (r_state == ST_ACC);
  assign w_full  = r_bits_left >= CntW'(64);
  assign w_take  = w_full ? CntW'(64) : r_bits_left;
  assign w_word  = mask_i & en_i & tail_mask(r_bits_left[5:0], w_full);

  ara_mask_popc_acc_bitops u_bitops (
    .i_word (w_word),
    .o_popc (w_popc),
    .o_tz   (w_tz)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start_i) w_state_next = (vl_i == '0) ? ST_DONE : ST_ACC;
      ST_ACC:  if (w_hs && !(r_bits_left > CntW'(64))) w_state_next = ST_DONE;
      ST_DONE: if (result_ready_i) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_op        <= POPC_CNT;
      r_bits_left <= '0;
      r_beat      <= '0;
      r_acc       <= '0;
      r_first     <= '0;
      r_found     <= 1'b0;
    end else if (w_start) begin
      r_op        <= op_i;
      r_bits_left <= vl_i;
      r_beat      <= '0;
      r_acc       <= '0;
      r_first     <= '0;
      r_found     <= 1'b0;
    end else if (w_hs) begin
      r_bits_left <= r_bits_left - w_take;
      r_beat      <= r_beat + 1'b1;
      if (r_op == POPC_CNT) begin
        r_acc <= r_acc + CntW'(w_popc);
      end else if (!r_found && (w_word != '0)) begin
        // Beat index times 64 plus the in-word offset is a plain concatenation.
        r_first <= {r_beat, w_tz};
        r_found <= 1'b1;
      end
    end
  end

  assign busy_o         = (r_state != ST_IDLE);
  assign mask_ready_o   = (r_state == ST_ACC);
  assign result_valid_o = (r_state == ST_DONE);

  always_comb begin
    result_o = '0;
    if (r_state == ST_DONE) begin
      if (r_op == POPC_CNT) result_o = 64'(r_acc);
      else if (r_found)     result_o = 64'(r_first);
      else                  result_o = '1;
    end
  end

endmodule

`default_nettype wire

// File: doc/ara_mask_popc_acc.md
# ara_mask_popc_acc

Sequential mask-reduction stage that sits directly downstream of the lane popcount unit and implements vcpop.m and vfirst.m. It accepts a stream of 64-bit mask words with a valid/ready handshake. On each beat it ANDs the mask word with the vm enable word and zeroes the tail bits beyond vl. It then either accumulates the per-word popcount or latches the index of the first set bit. A single 64-bit scalar result goes back over a valid/ready handshake.

## Interface
Parameters:
- MaxVl, default 16384: maximum mask length in bits.
- CntW, default $clog2(MaxVl+1): width of vl and internal counters (derived; do not override).

Ports:
- Clocking and reset: one clock `clk_i`; reset `rst_ni` is asynchronous and active-low.
- clk_i, in, 1: clock.
- rst_ni, in, 1: asynchronous active-low reset.
- start_i, in, 1: start pulse. Sampled only in IDLE.
- op_i, in, popc_op_e: POPC_CNT or POPC_FIRST. Sampled with start_i.
- vl_i, in, CntW: mask length in bits. Sampled with start_i.
- busy_o, out, 1: high whenever the state is not IDLE.
- mask_valid_i, in, 1: mask beat valid.
- mask_ready_o, out, 1: stage accepts a mask beat.
- mask_i, in, 64: mask word. Bit 0 is element beat*64.
- en_i, in, 64: vm enable word. Set it to all ones when unmasked.
- result_valid_o, out, 1: result available.
- result_ready_i, in, 1: consumer accepts the result.
- result_o, out, 64: the count, or the first index sign-extended (-1 when no bit is set).

## Operation
- States: IDLE, ACC, DONE.
- IDLE:
  - On start_i, latch op, set bits_left=vl_i, beat=0, acc=0, found=0, first=0.
  - If vl_i==0, go to DONE. Otherwise go to ACC.
- ACC:
  - mask_ready_o=1. Each handshake (mask_valid_i & mask_ready_o) is one beat.
  - w = mask_i & en_i & tailmask. tailmask is all ones if bits_left>=64, otherwise (1<<bits_left)-1.
  - POPC_CNT: acc += popcount(w), with zero-extension to CntW.
  - POPC_FIRST: if !found and w!=0, then first = beat*64 + tz(w) and found=1. Later beats never update first.
  - Every beat: bits_left -= min(64, bits_left) and beat += 1.
  - When the beat just accepted makes bits_left reach 0, go to DONE.
  - All ceil(vl/64) beats are always consumed, even after found=1. No early exit.
- DONE:
  - result_valid_o=1.
  - result_o for POPC_CNT: zero-extended acc.
  - result_o for POPC_FIRST: zero-extended first if found, otherwise 64'hFFFF_FFFF_FFFF_FFFF.
  - On result_ready_i, go to IDLE.
- start_i outside IDLE is ignored. It is neither queued nor errored.
- Beats offered outside ACC are not accepted (mask_ready_o=0).
- Arithmetic: acc never overflows because acc ≤ vl ≤ MaxVl < 2^CntW. No saturation logic.

## Timing
- Reset values:
  - state=IDLE.
  - busy_o=0, mask_ready_o=0, result_valid_o=0, result_o=0.
  - acc, first, found, bits_left and beat are all 0.
- Reset asserted mid-operation aborts immediately to IDLE. Partial results are discarded.
- start_i to mask_ready_o: 1 cycle.
- Accumulation happens in the handshake cycle. The register update is visible the next cycle. Throughput is 1 beat/cycle.
- Final beat accepted in cycle N: result_valid_o=1 in cycle N+1.
- result_o is held stable while result_valid_o=1 and result_ready_i=0.
- result_valid_o may be high in the same cycle as result_ready_i. The handshake completes that cycle, and the next start is accepted in the following cycle.
- vl_i==0: result_valid_o=1 in the cycle after start_i, with no mask beats.
- All outputs are registered or decoded from state only. There is no combinational path from mask_valid_i or result_ready_i to any output.

## Structure
- ara_pkg: typedef enum logic {POPC_CNT, POPC_FIRST} popc_op_e.
- Sub-module: instantiate the existing ara_popcnt on w. Use only its 64-bit result, truncated to 7 bits.
- Trailing-zero count: common_cells lzc (MODE=0, WIDTH=64). The empty flag is ignored because it is gated by w!=0.
- One FSM process plus datapath registers, all with async active-low reset.

## Test plan
- POPC_CNT, vl=64, mask=all ones, en=all ones -> one beat accepted, result_o=64.
- POPC_CNT, vl=100, two beats of all ones, en=all ones -> tail masked, result_o=100, result_valid_o high one cycle after beat 2.
- POPC_FIRST, vl=200, beats {0, 0x10, 0x1} -> 4 beats consumed (ceil(200/64)=4), result_o=64+4=68. Also check that the later set bit is ignored.
- POPC_FIRST, vl=10, mask=0xFFFF_FC00, en=all ones -> all set bits lie past vl, so result_o=-1 (all ones). Also check vl=0 -> result_o=-1 with no beats accepted.
- POPC_CNT, mask=all ones, en=0x5555…, vl=128, with result_ready_i held low 5 cycles -> result_o=64 held stable, and start_i pulses during DONE are ignored.
- Reset mid-ACC after 1 of 3 beats -> all outputs return to reset values. A new op started afterwards (POPC_CNT, vl=8, mask=0xFF) gives result_o=8.
